if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with a decoupling prefetch queue between instruction memory and ID. It owns the PC and issues one fetch per cycle to a fixed 1-cycle-latency instruction memory. Returned words are buffered with their PC+4 and handed to ID over a valid/ready handshake. Branch, jump, jr, interrupt and exception redirects flush the queue and drop the in-flight fetch. It replaces the single-register IF/ID latch and its bubble/pause scheme.

Parameters:
INSTR_W, 32, instruction word width
ADDR_W, 32, PC width; KERNEL_BIT = ADDR_W-1 is the supervisor bit
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_VEC, 32'h8000_0000, PC after reset
IRQ_VEC, 32'h8000_0004, interrupt target
EXC_VEC, 32'h8000_0008, exception target

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
hold  in  1  global freeze (UART wait); while high no state changes
pc_src  in  3  {JR, J, B} redirect select, one-hot or zero
branch_address  in  ADDR_W  B target
jump_address  in  ADDR_W  J target
jr_address  in  ADDR_W  JR/JALR target
interrupt  in  1  interrupt request
exception  in  1  exception request
imem_req  out  1  fetch request this cycle
imem_addr  out  ADDR_W  fetch address (= PC)
imem_rdata  in  INSTR_W  data for the request issued in the previous cycle
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head
id_pc_plus4  out  ADDR_W  head PC+4 with kernel bit
id_instr  out  INSTR_W  head instruction

Behaviour:
- Reset: PC=RESET_VEC, queue empty (count=0, pointers 0), inflight=0. id_valid=0, imem_req=0. id_pc_plus4 and id_instr read 0 while empty.
- hold=1: PC, queue, pointers, inflight and the captured response are all frozen. imem_req=0. Redirect inputs and the pop are ignored; sources must hold them. A response due in a held cycle is captured when hold falls. The memory honours the same hold.
- pop = id_valid & id_ready & ~hold & ~redirect.
- Issue: imem_req = ~hold & ~redirect & (count + inflight - pop < DEPTH); imem_addr = PC.
- inflight <= imem_req. The response arrives the following non-held cycle and is written at tail as {pc_plus4_of_request, imem_rdata}.
- pc_plus4 = {PC[KERNEL_BIT] | interrupt | exception, PC[KERNEL_BIT-1:0] + 4}. Low bits wrap modulo 2^(ADDR_W-1). The kernel bit never carries.
- Redirect, in priority order, evaluated when ~hold:
  1. interrupt & ~PC[KERNEL_BIT] -> IRQ_VEC
  2. exception & ~PC[KERNEL_BIT] -> EXC_VEC
  3. pc_src 100 -> jr_address; 010 -> jump_address; 001 -> branch_address
  4. multi-hot pc_src -> all ones (error trap)
  5. pc_src 000 -> no redirect
- Interrupt and exception are ignored when PC[KERNEL_BIT]=1.
- On redirect, in one edge: PC <= target, count <= 0, head=tail, and the in-flight response is discarded (inflight <= 0, no write). id_valid is 0 in the next cycle. The first fetch from the target issues that next cycle, and id_valid rises 2 cycles after that issue.
- No redirect & imem_req: PC <= PC + 4 in the low bits; the kernel bit is preserved.
- Queue: count and pointer updates are simultaneous. A write and a pop in the same cycle leave count unchanged. Overflow is impossible by issue-credit construction; an overflow is an assertion failure. Pointers wrap at DEPTH.
- Latency: a fetch issued in cycle t makes id_valid high in cycle t+2 with an empty queue. Steady-state throughput is 1 instruction/cycle when id_ready=1 for any DEPTH >= 2.
- Reset asserted mid-operation overrides hold and redirect; all state returns to its reset values at that edge.

Test Plan:
- Reset then id_ready=1, memory returns addr-derived words -> id_pc_plus4 = 8000_0004, 8000_0008, ... in consecutive cycles from cycle 2; no gaps.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered and imem_req=0 afterwards. On release, those 4 drain back-to-back, then flow continues in order with no loss or duplicate.
- PC=0000_0100 user mode, pc_src=001, branch_address=0000_0200 with one fetch in flight -> queue flushed, in-flight word dropped, next imem_addr=0000_0200, next id_pc_plus4=0000_0204.
- interrupt=1 and pc_src=010 same cycle, PC user mode -> PC=8000_0004 (interrupt wins). Repeat with PC=8000_0010 -> interrupt ignored, PC=jump_address.
- pc_src=011 -> PC=FFFF_FFFF.
- hold=1 for 5 cycles mid-stream with an in-flight response and pending pop -> no output change, no request, PC frozen. After release, the sequence resumes with no loss or duplicate. Reset asserted during hold -> PC=8000_0000, id_valid=0.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// Instruction-fetch bus bundle for if_prefetch_stage.
//   imem_req    fetch request this cycle (stage -> memory)
//   imem_addr   fetch address, equal to the stage PC (stage -> memory)
//   imem_rdata  word for the request issued one non-held cycle earlier (memory -> stage)
//   id_valid    prefetch queue head valid (stage -> ID)
//   id_ready    ID accepts the head this cycle (ID -> stage)
//   id_pc_plus4 head PC+4 including the kernel bit (stage -> ID)
//   id_instr    head instruction word (stage -> ID)
// The master modport is the fetch stage; the slave modport is the memory/ID side.
interface if_prefetch_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc_plus4;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc_plus4, id_instr,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc_plus4, id_instr,
    output imem_rdata, id_ready
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a decoupling prefetch queue.
// Owns the PC, issues at most one fetch per cycle to a 1-cycle-latency
// instruction memory, buffers returned words with their PC+4 and hands them
// to ID over valid/ready. Redirects (interrupt, exception, JR, J, B) flush the
// queue and drop the in-flight fetch.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   hold            global freeze; no state changes while high
//   pc_src          {JR, J, B} redirect select, one-hot or zero
//   branch_address, jump_address, jr_address   redirect targets
//   interrupt, exception                       ignored in kernel mode
//   bus             fetch/ID bundle (master side)
module if_prefetch_stage #(
  parameter int              INSTR_W   = 32,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [2:0]        pc_src,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic [ADDR_W-1:0] jr_address,
  input  logic              interrupt,
  input  logic              exception,
  if_prefetch_stage_if.master bus
);
  localparam int K  = ADDR_W - 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc;
  logic [CW-1:0]      count;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               vld_p1;       // a fetch is in flight to the memory
  logic [ADDR_W-1:0]  req_pc4_p1;   // PC+4 of that fetch
  logic [ADDR_W-1:0]  q_pc4   [DEPTH];
  logic [INSTR_W-1:0] q_instr [DEPTH];

  logic               take_irq;
  logic               take_exc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_tgt;
  logic               head_vld;
  logic               pop;
  logic               wr;
  logic               fetch;
  logic [CW:0]        credit;

  // Kernel bit is forced, never carried into; low bits wrap.
  function automatic logic [ADDR_W-1:0] seq_next(input logic [ADDR_W-1:0] a,
                                                 input logic kern);
    return {kern, a[K-1:0] + K'(4)};
  endfunction

  assign take_irq = interrupt & ~pc[K];
  assign take_exc = exception & ~pc[K];
  assign redirect = ~hold & (take_irq | take_exc | (|pc_src));

  always_comb begin
    redirect_tgt = '1;
    if (take_irq)      redirect_tgt = IRQ_VEC;
    else if (take_exc) redirect_tgt = EXC_VEC;
    else begin
      case (pc_src)
        3'b100:  redirect_tgt = jr_address;
        3'b010:  redirect_tgt = jump_address;
        3'b001:  redirect_tgt = branch_address;
        default: redirect_tgt = '1;   // multi-hot select traps to all ones
      endcase
    end
  end

  assign head_vld = (count != '0);
  assign pop      = head_vld & bus.id_ready & ~hold & ~redirect;
  assign wr       = vld_p1 & ~hold & ~redirect;

  // Issue credit: entries held plus the one landing this cycle, minus the pop,
  // must leave room for the word this request returns next cycle.
  assign credit = (CW+1)'(count) + (CW+1)'(vld_p1) - (CW+1)'(pop);
  assign fetch  = ~reset & ~hold & ~redirect & (credit < (CW+1)'(DEPTH));

  assign bus.imem_req    = fetch;
  assign bus.imem_addr   = pc;
  assign bus.id_valid    = head_vld;
  assign bus.id_pc_plus4 = head_vld ? q_pc4[head]   : '0;
  assign bus.id_instr    = head_vld ? q_instr[head] : '0;

  // Stage p0 -> p1: PC, request tracking and queue control
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_VEC;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      vld_p1 <= 1'b0;
    end else if (!hold) begin
      vld_p1 <= fetch;
      if (redirect) begin
        pc    <= redirect_tgt;
        count <= '0;
        head  <= tail;
      end else begin
        if (fetch) pc   <= seq_next(pc, pc[K]);
        if (wr)    tail <= tail + 1'b1;
        if (pop)   head <= head + 1'b1;
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end

  // Stage p1 -> queue: response data, captured alongside its request PC+4
  always_ff @(posedge clk) begin
    if (fetch) req_pc4_p1 <= seq_next(pc, pc[K] | interrupt | exception);
    if (wr) begin
      q_pc4[tail]   <= req_pc4_p1;
      q_instr[tail] <= bus.imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(wr && !pop && count == CW'(DEPTH)));
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a table of per-cycle stimulus and
// expected outputs, followed by a hand-written reset-during-hold sequence.
// The instruction memory model returns addr ^ 5A5A5A5A one cycle after the
// request and freezes its output while hold is high.
module tb_if_prefetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  pc_src;
  logic [31:0] branch_address;
  logic [31:0] jump_address;
  logic [31:0] jr_address;
  logic        interrupt;
  logic        exception;
  int          n_vec = 0;
  int          n_bad = 0;

  if_prefetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  if_prefetch_stage #(.INSTR_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .pc_src         (pc_src),
    .branch_address (branch_address),
    .jump_address   (jump_address),
    .jr_address     (jr_address),
    .interrupt      (interrupt),
    .exception      (exception),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!hold) bus.imem_rdata <= bus.imem_addr ^ 32'h5A5A_5A5A;

  typedef struct {
    logic        hold;
    logic        rdy;
    logic [2:0]  src;
    logic        irq;
    logic        exc;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc4;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic h, input logic r, input logic [2:0] s,
                     input logic i, input logic e, input logic [31:0] t,
                     input logic q, input logic [31:0] a, input logic v,
                     input logic [31:0] p);
    vec_t x;
    x.hold = h; x.rdy = r; x.src = s; x.irq = i; x.exc = e; x.tgt = t;
    x.req = q; x.addr = a; x.vld = v; x.pc4 = p;
    tv.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    hold           = x.hold;
    bus.id_ready   = x.rdy;
    pc_src         = x.src;
    interrupt      = x.irq;
    exception      = x.exc;
    branch_address = x.tgt;
    jump_address   = x.tgt + 32'h10;
    jr_address     = x.tgt + 32'h20;
  endtask

  task automatic check(input string name, input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] pc4);
    logic [30:0] lo;
    logic [31:0] ei;
    lo = pc4[30:0] - 31'd4;
    ei = vld ? ({pc4[31], lo} ^ 32'h5A5A_5A5A) : 32'h0;
    n_vec++;
    if (bus.imem_req !== req || bus.imem_addr !== addr || bus.id_valid !== vld ||
        bus.id_pc_plus4 !== pc4 || bus.id_instr !== ei) begin
      n_bad++;
      $display("FAIL %s: got req=%b addr=%h vld=%b pc4=%h instr=%h; want req=%b addr=%h vld=%b pc4=%h instr=%h",
               name, bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc_plus4,
               bus.id_instr, req, addr, vld, pc4, ei);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Streaming from reset, ready high
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0000,0,32'h0);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0004,0,32'h0);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0008,1,32'h8000_0004);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_000C,1,32'h8000_0008);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0010,1,32'h8000_000C);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0014,1,32'h8000_0010);
    // Backpressure for 10 cycles: queue fills to 4 and issue stops
    add(0,0,3'b000,0,0,32'h0, 1,32'h8000_0018,1,32'h8000_0014);
    add(0,0,3'b000,0,0,32'h0, 1,32'h8000_001C,1,32'h8000_0014);
    for (int i = 0; i < 8; i++)
      add(0,0,3'b000,0,0,32'h0, 0,32'h8000_0020,1,32'h8000_0014);
    // Drain back-to-back, then flow continues
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0020,1,32'h8000_0014);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0024,1,32'h8000_0018);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0028,1,32'h8000_001C);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_002C,1,32'h8000_0020);
    add(0,1,3'b000,0,0,32'h0, 1,32'h8000_0030,1,32'h8000_0024);
    // Jump to user mode 0xFC, then branch to 0x200 with 0xFC in flight
    add(0,1,3'b010,0,0,32'hEC, 0,32'h8000_0034,1,32'h8000_0028);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_00FC,0,32'h0);
    add(0,1,3'b001,0,0,32'h200,0,32'h0000_0100,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0200,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0204,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0208,1,32'h0000_0204);
    // Interrupt beats jump in user mode
    add(0,1,3'b010,1,0,32'h0,  0,32'h0000_020C,1,32'h0000_0208);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_0004,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_0008,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_000C,1,32'h8000_0008);
    // Interrupt ignored in kernel mode: jump to 0x10
    add(0,1,3'b010,1,0,32'h0,  0,32'h8000_0010,1,32'h8000_000C);
    // Exception in user mode
    add(0,1,3'b000,0,1,32'h0,  0,32'h0000_0010,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_0008,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_000C,0,32'h0);
    // Multi-hot select traps to all ones; low bits then wrap
    add(0,1,3'b011,0,0,32'h0,  0,32'h8000_0010,1,32'h8000_000C);
    add(0,1,3'b000,0,0,32'h0,  1,32'hFFFF_FFFF,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_0003,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h8000_0007,1,32'h8000_0003);
    // JR redirect to 0x120
    add(0,1,3'b100,0,0,32'h100,0,32'h8000_000B,1,32'h8000_0007);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0120,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0124,0,32'h0);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0128,1,32'h0000_0124);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_012C,1,32'h0000_0128);
    // Hold 5 cycles with a response in flight and a pop pending
    for (int i = 0; i < 5; i++)
      add(1,1,3'b000,0,0,32'h0, 0,32'h0000_0130,1,32'h0000_012C);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0130,1,32'h0000_012C);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0134,1,32'h0000_0130);
    add(0,1,3'b000,0,0,32'h0,  1,32'h0000_0138,1,32'h0000_0134);

    reset = 1'b1;
    drive(tv[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 1'b0, 32'h8000_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), tv[i].req, tv[i].addr, tv[i].vld, tv[i].pc4);
      @(posedge clk); #1;
    end

    // Reset asserted while hold is high
    hold = 1'b1;
    @(negedge clk);
    check("hold_pre_reset", 1'b0, 32'h0000_013C, 1'b1, 32'h0000_0138);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_req_gate", 1'b0, 32'h0000_013C, 1'b1, 32'h0000_0138);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_hold", 1'b0, 32'h8000_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    check("restart0", 1'b1, 32'h8000_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("restart1", 1'b1, 32'h8000_0004, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("restart2", 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
